// File: rtl/gpio_input_ctrl.sv
// Board switch/button input conditioning: 2-FF synchronizer, per-bit counter debounce,
// sticky press capture and a 4-word register port with a level interrupt.
module gpio_input_ctrl #(
    parameter int NUM_SW          = 10,
    parameter int NUM_PB          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PB_ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic [NUM_SW-1:0] switches,
    input  logic [NUM_PB-1:0] push_buttons,
    input  logic [1:0]        bus_addr,
    input  logic              bus_wr_en,
    input  logic              bus_rd_en,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic              irq
);

    localparam int W  = NUM_SW + NUM_PB;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          PB_INV  = (PB_ACTIVE_LOW != 0);

    logic [W-1:0]      in_raw;
    logic [W-1:0]      sync1_q, sync2_q;
    logic [W-1:0]      stable_q, stable_d;
    logic [CW-1:0]     cnt_q [W];
    logic [CW-1:0]     cnt_d [W];
    logic [NUM_PB-1:0] stable_pb_d_q;
    logic [NUM_PB-1:0] edge_q, edge_d;
    logic [NUM_PB-1:0] irq_en_q, irq_en_d;
    logic [NUM_PB-1:0] press_evt, w1c;
    logic [31:0]       rdata_q, rdata_d, reg_val;
    logic              rvalid_q;
    logic              unused_wdata;

    // Everything downstream of this point uses 1 = on/pressed.
    assign in_raw = {push_buttons ^ {NUM_PB{PB_INV}}, switches};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < W; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A press landing on the same cycle as its W1C keeps the bit set.
    always_comb begin
        press_evt = stable_q[W-1:NUM_SW] & ~stable_pb_d_q;
        w1c       = (bus_wr_en && bus_addr == 2'd1) ? bus_wdata[NUM_PB-1:0] : '0;
        edge_d    = (edge_q & ~w1c) | press_evt;
        irq_en_d  = (bus_wr_en && bus_addr == 2'd2) ? bus_wdata[NUM_PB-1:0] : irq_en_q;
    end

    always_comb begin
        reg_val = '0;
        case (bus_addr)
            2'd0:    reg_val = 32'(stable_q);
            2'd1:    reg_val = 32'(edge_q);
            2'd2:    reg_val = 32'(irq_en_q);
            default: reg_val = 32'(sync2_q);
        endcase
        rdata_d = bus_rd_en ? reg_val : rdata_q;
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_pb_d_q <= '0;
            edge_q        <= '0;
            irq_en_q      <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q       <= in_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_pb_d_q <= stable_q[W-1:NUM_SW];
            edge_q        <= edge_d;
            irq_en_q      <= irq_en_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= bus_rd_en;
            for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus_rdata    = rdata_q;
    assign bus_rvalid   = rvalid_q;
    assign irq          = |(edge_q & irq_en_q);
    assign unused_wdata = ^bus_wdata[31:NUM_PB];

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Scoreboarded bench for gpio_input_ctrl: directed scenarios plus random pin/bus traffic
// compared against a sample-history reference model.
module tb_gpio_input_ctrl;
    localparam int NSW = 10;
    localparam int NPB = 4;
    localparam int DB  = 4;
    localparam int W   = NSW + NPB;

    logic           clk = 1'b0;
    logic           async_rst;
    logic [NSW-1:0] switches;
    logic [NPB-1:0] push_buttons;
    logic [1:0]     bus_addr;
    logic           bus_wr_en, bus_rd_en;
    logic [31:0]    bus_wdata, bus_rdata;
    logic           bus_rvalid, irq;

    always #5 clk = ~clk;

    gpio_input_ctrl #(.NUM_SW(NSW), .NUM_PB(NPB), .DEBOUNCE_CYCLES(DB), .PB_ACTIVE_LOW(1)) dut (
        .clk(clk), .async_rst(async_rst), .switches(switches), .push_buttons(push_buttons),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] val; string tag; } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_rdata = '0;

    // Reference model: a bit is accepted once the last DB synchronized samples all disagree with it.
    logic [W-1:0]   m_s1, m_s2, m_stable;
    logic [W-1:0]   m_hist [DB];
    logic [NPB-1:0] m_pb_prev, m_edge, m_irq_en;

    function automatic void model_clear();
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_pb_prev = '0; m_edge = '0; m_irq_en = '0;
        for (int k = 0; k < DB; k++) m_hist[k] = '0;
    endfunction

    function automatic void model_step();
        logic [NPB-1:0] press, clr;
        logic           all_diff;
        press     = m_stable[W-1:NSW] & ~m_pb_prev;
        m_pb_prev = m_stable[W-1:NSW];
        clr       = (bus_wr_en && bus_addr == 2'd1) ? bus_wdata[NPB-1:0] : '0;
        if (bus_wr_en && bus_addr == 2'd2) m_irq_en = bus_wdata[NPB-1:0];
        m_edge = (m_edge & ~clr) | press;
        for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) m_stable[i] = ~m_stable[i];
        end
        m_s2 = m_s1;
        m_s1 = {~push_buttons, switches};
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_edge);
            2'd2:    return 32'(m_irq_en);
            default: return 32'(m_s2);
        endcase
    endfunction

    always @(posedge clk) if (!async_rst) model_step();

    // Monitor: irq every cycle, read data whenever rvalid, hold behaviour otherwise.
    always @(negedge clk) begin
        checks++;
        if (irq !== |(m_edge & m_irq_en)) begin
            errors++;
            $display("FAIL irq_level: got %b expected %b at %0t", irq, |(m_edge & m_irq_en), $time);
        end
        checks++;
        if (bus_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: got rvalid=1 expected no read pending at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                if (bus_rdata !== mon_e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h at %0t", mon_e.tag, bus_rdata, mon_e.val, $time);
                end
                last_rdata = mon_e.val;
            end
        end else if (bus_rvalid !== 1'b0 || bus_rdata !== last_rdata) begin
            errors++;
            $display("FAIL rdata_hold: got rvalid=%b rdata=%h expected rvalid=0 rdata=%h at %0t",
                     bus_rvalid, bus_rdata, last_rdata, $time);
        end
    end

    task automatic push_exp(input logic [31:0] v, input string tag);
        exp_t e;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic rdc(input logic [1:0] a, input logic [31:0] v, input string tag);
        bus_addr = a; bus_rd_en = 1'b1;
        push_exp(v, tag);
        @(negedge clk);
        bus_rd_en = 1'b0;
    endtask

    task automatic rdm(input logic [1:0] a, input string tag);
        rdc(a, m_reg(a), tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_wr_en = 1'b1;
        @(negedge clk);
        bus_wr_en = 1'b0;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] v, input string tag);
        bus_addr = a; bus_wdata = d; bus_wr_en = 1'b1; bus_rd_en = 1'b1;
        push_exp(v, tag);
        @(negedge clk);
        bus_wr_en = 1'b0; bus_rd_en = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        model_clear();
        bus_addr = '0; bus_wr_en = 1'b0; bus_rd_en = 1'b0; bus_wdata = '0;
        switches = '0; push_buttons = '1; async_rst = 1'b0;
        #1 async_rst = 1'b1;
        idle(3);
        #2 async_rst = 1'b0;
        idle(8);

        // idle after reset
        rdc(0, 32'h0, "idle_state");
        rdc(1, 32'h0, "idle_edge");
        rdm(3, "idle_raw");

        // switch 9: STATE after 6 edges
        switches = 10'h200;
        for (int i = 1; i <= 8; i++) rdc(0, (i >= 7) ? 32'h200 : 32'h0, "sw9_state_latency");
        // switch 0: RAW after 2 edges
        switches = 10'h201;
        for (int i = 1; i <= 3; i++) rdc(3, (i >= 3) ? 32'h201 : 32'h200, "sw0_raw_latency");
        idle(8);

        // bouncing button 0, then held
        push_buttons = 4'hE; rdc(0, 32'h201, "bounce_state"); rdc(0, 32'h201, "bounce_state");
        push_buttons = 4'hF; rdc(0, 32'h201, "bounce_state"); rdc(0, 32'h201, "bounce_state");
        push_buttons = 4'hE;
        for (int i = 1; i <= 7; i++) rdc(0, (i >= 7) ? 32'h601 : 32'h201, "pb0_state_latency");
        rdc(1, 32'h1, "edge_pb0");

        // irq rise / W1C fall / no release edge
        wr(1, 32'h1);
        push_buttons = 4'hF;
        idle(8);
        rdc(1, 32'h0, "edge_cleared");
        wr(2, 32'h1);
        push_buttons = 4'hE;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("irq_rise_timing", 32'(irq), (i >= 7) ? 32'h1 : 32'h0);
        end
        wr(1, 32'h1);
        chk("irq_fall_after_w1c", 32'(irq), 32'h0);
        push_buttons = 4'hF;
        idle(10);
        rdc(1, 32'h0, "no_release_edge");
        chk("irq_after_release", 32'(irq), 32'h0);

        // W1C on the press cycle: set wins
        wr(2, 32'hFFFF_FFF2);
        rdc(2, 32'h2, "irq_en_mask");
        push_buttons = 4'hD;
        idle(6);
        wr(1, 32'h2);
        rdc(1, 32'h2, "w1c_vs_set");
        chk("irq_held_set_wins", 32'(irq), 32'h1);
        rdwr(1, 32'h2, 32'h2, "rdwr_old_value");
        rdc(1, 32'h0, "w1c_after_rdwr");
        wr(0, 32'hFFFF_FFFF);
        rdm(0, "ro_write_ignored");
        push_buttons = 4'hF;
        idle(8);

        // reset mid-debounce
        push_buttons = 4'hD; idle(8);
        push_buttons = 4'hF; switches = '0; idle(8);
        chk("irq_before_reset", 32'(irq), 32'h1);
        switches = 10'h008;
        rdc(2, 32'h2, "pre_reset_irqen");
        idle(3);
        #2 async_rst = 1'b1;
        model_clear();
        last_rdata = '0;
        #1;
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_rvalid", 32'(bus_rvalid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        idle(2);
        #2 async_rst = 1'b0;
        for (int i = 1; i <= 7; i++) rdc(0, (i >= 7) ? 32'h8 : 32'h0, "sw3_after_reset");
        rdc(1, 32'h0, "edge_after_reset");
        rdc(2, 32'h0, "irqen_after_reset");

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) switches[$urandom_range(0, NSW-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) push_buttons[$urandom_range(0, NPB-1)] ^= 1'b1;
            bus_addr  = 2'($urandom);
            bus_wdata = $urandom;
            bus_rd_en = ($urandom_range(0, 1) == 1);
            bus_wr_en = ($urandom_range(0, 5) == 0);
            if (bus_rd_en) push_exp(m_reg(bus_addr), "rand_read");
            @(negedge clk);
        end
        bus_rd_en = 1'b0; bus_wr_en = 1'b0;
        idle(3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_input_ctrl.md
Name: gpio_input_ctrl

Overview:
- Input-side counterpart to the LED output path.
- Conditions the board's 10 slide switches and 4 push buttons: 2-FF synchronizer, per-bit counter debounce, and sticky press-edge capture.
- Exposes the debounced state, captured presses and an interrupt to the SRV1 core through a small memory-mapped register port.
- Sits in toplevel between the board pins (switches, push_buttons) and the core's data bus.

Parameters:
- NUM_SW, 10, number of switch inputs (1..16).
- NUM_PB, 4, number of push-button inputs (1..16).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before an input change is accepted (>=2; the bench uses 4).
- PB_ACTIVE_LOW, 1, 1 means buttons read 0 when pressed; they are inverted before the synchronizer.

Ports:
- clk  input  1  system clock.
- async_rst  input  1  asynchronous active-high reset.
- switches  input  NUM_SW  raw switch pins, asynchronous to clk.
- push_buttons  input  NUM_PB  raw button pins, asynchronous to clk.
- bus_addr  input  2  word select (byte address bits [3:2]).
- bus_wr_en  input  1  write strobe, one cycle.
- bus_rd_en  input  1  read strobe, one cycle.
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data, valid the cycle after bus_rd_en.
- bus_rvalid  output  1  pulses 1 cycle after bus_rd_en.
- irq  output  1  level interrupt, |(edge & irq_en).

Behaviour:
- Reset (async assert, sync release):
  - All sync FFs, debounce counters, stable state, edge and irq_en are cleared to 0.
  - bus_rdata=0, bus_rvalid=0, irq=0.
  - Reset mid-debounce discards partial counts.
- Input conditioning:
  - Buttons are XORed with PB_ACTIVE_LOW before sync, so all internal state is "1 = on/pressed".
  - Vector in = {pb_logical, switches}, W = NUM_PB+NUM_SW.
  - Each bit passes through a 2-FF synchronizer to give sync[i].
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES):
  - sync==stable: counter<=0.
  - sync!=stable and counter<DEBOUNCE_CYCLES-1: counter++.
  - sync!=stable and counter==DEBOUNCE_CYCLES-1: stable<=sync, counter<=0.
  - A pin change held steady appears on stable exactly 2+DEBOUNCE_CYCLES clock edges after the first edge that samples it.
  - Any bounce back before acceptance restarts the count from 0.
- Edge capture, buttons only:
  - press_evt[j] = stable_pb[j] & ~stable_pb_d[j] (rising edge of debounced pressed).
  - edge[j] is set by press_evt and cleared by writing 1 to that bit of the EDGE register.
  - Same-cycle set and W1C on one bit: set wins.
  - Release events are not captured.
- irq is combinational from registers: irq = |(edge & irq_en). No glitch path from pins.
- Register map (word index):
  - 0 STATE (RO): [NUM_SW-1:0] debounced switches; [NUM_SW+NUM_PB-1:NUM_SW] debounced buttons; upper bits 0.
  - 1 EDGE (R/W1C): [NUM_PB-1:0] captured presses.
  - 2 IRQ_EN (RW): [NUM_PB-1:0] per-button interrupt mask; upper write bits ignored.
  - 3 RAW (RO): synchronized, un-debounced vector (same bit layout as STATE).
  - Writes to RO registers are ignored.
- Read timing:
  - bus_rdata and bus_rvalid are registered and present the register value as of the bus_rd_en edge.
  - When not reading, bus_rdata holds its last value and bus_rvalid=0.
  - Read of EDGE in the same cycle as a press: returns the pre-set value; the bit appears on the next read.
- Simultaneous bus_rd_en and bus_wr_en to the same address: the read returns the old value and the write takes effect.
- Back-to-back reads on consecutive cycles are supported (throughput 1/cycle).

Test Plan:
- Reset then idle, DEBOUNCE_CYCLES=4, PB_ACTIVE_LOW=1, push_buttons=4'hF, switches=0 -> STATE reads 0, EDGE 0, irq 0.
- Set switches=10'h200 and hold -> STATE bit 9 set exactly 6 cycles after the change; RAW shows it after 2 cycles.
- push_buttons[0] bounces 0,1,0 with each level held 2 cycles, then holds 0 -> STATE stays 0 during the bounce; bit 10 sets 6 cycles after the final hold begins; EDGE reads 0x1.
- IRQ_EN=0x1, press button 0 -> irq rises 1 cycle after STATE updates; write EDGE=0x1 -> irq falls next cycle; release creates no new edge.
- W1C of EDGE[1] issued on the same cycle as a new press of button 1 -> EDGE[1] remains 1, irq stays asserted.
- Assert async_rst mid-debounce (counter=2) on switch 3 -> all outputs 0 immediately; after release the switch needs a full 6 cycles to appear.
